// File: rtl/mem_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_hs
// Purpose  : MEM pipeline stage with a req/ack data-memory handshake.
//            It handles byte/half/word loads and stores and sign/zero-extends
//            loaded data. Misaligned accesses are dropped and flagged. The
//            stage owns the MEM/WB output register.
// Options  : MEM_TIMEOUT_EN - aborts an access that is not acknowledged
//            within TIMEOUT_CYC REQ cycles and pulses bus_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_hs #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [31:0]       result_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wrdata_i,
  input  logic              wrn_i,
  input  logic [REG_AW-1:0] wrAddr_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wrn_o,
  output logic [REG_AW-1:0] wrAddr_o,
  output logic [31:0]       result_o,
  output logic              align_err_o,
  output logic              bus_err_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [0:0]        r_state;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_op;
  logic [1:0]        r_lane;
  logic              r_load;
  logic              r_wrn;
  logic [REG_AW-1:0] r_wa;
  logic              r_wrn_o;
  logic [REG_AW-1:0] r_wa_o;
  logic [31:0]       r_res;
  logic              r_align_err;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic [1:0]        w_size;
  logic [1:0]        w_lane;
  logic              w_misalign;
  logic              w_start;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_data;
  logic              w_tmo;

  // Decode the op code into direction and access size
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_WORD;
    case (mem_op_i)
      4'd1, 4'd2: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
      4'd3, 4'd4: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
      4'd5:       begin w_is_load  = 1'b1; w_size = SZ_WORD; end
      4'd9:       begin w_is_store = 1'b1; w_size = SZ_BYTE; end
      4'd10:      begin w_is_store = 1'b1; w_size = SZ_HALF; end
      4'd11:      begin w_is_store = 1'b1; w_size = SZ_WORD; end
      default:    ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_lane     = mem_addr_i[1:0];
  assign w_misalign = ((w_size == SZ_HALF) && w_lane[0]) ||
                      ((w_size == SZ_WORD) && (w_lane != 2'b00));
  assign w_start    = valid_i & w_is_mem & ~w_misalign;

  // Byte enables and lane-replicated store data for the current access
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_wrdata_i;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{mem_wrdata_i[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_wrdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the read word and extend it
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_op)
      OP_LB:   w_ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ld_data = {24'd0, w_byte};
      OP_LH:   w_ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = dmem_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  // The limit is hit in the REQ cycle that would be the TIMEOUT_CYC-th without ack
  assign w_tmo = (r_state == S_REQ) && !dmem_ack_i &&
                 (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count REQ cycles without ack; held at zero while idle so each access starts fresh
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (!dmem_ack_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus_err_o = r_bus_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYC != 0);
  assign w_tmo        = 1'b0;
  assign bus_err_o    = 1'b0;
`endif

  assign stall_o = (r_state == S_IDLE) ? w_start : (~dmem_ack_i & ~w_tmo);

  // Handshake FSM plus the MEM/WB output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_op        <= 4'd0;
      r_lane      <= 2'd0;
      r_load      <= 1'b0;
      r_wrn       <= 1'b0;
      r_wa        <= '0;
      r_wrn_o     <= 1'b0;
      r_wa_o      <= '0;
      r_res       <= 32'd0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i && w_is_mem) begin
            r_wrn_o <= 1'b0;
            if (w_misalign) begin
              r_align_err <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_we    <= w_is_store;
              r_be    <= w_be;
              r_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              r_wdata <= w_wdata;
              r_op    <= mem_op_i;
              r_lane  <= w_lane;
              r_load  <= w_is_load;
              r_wrn   <= wrn_i;
              r_wa    <= wrAddr_i;
            end
          end else begin
            r_wrn_o <= valid_i & wrn_i;
            r_wa_o  <= wrAddr_i;
            r_res   <= result_i;
          end
        end
        default: begin
          if (dmem_ack_i) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            if (r_load) begin
              r_wrn_o <= r_wrn;
              r_wa_o  <= r_wa;
              r_res   <= w_ld_data;
            end else begin
              r_wrn_o <= 1'b0;
            end
          end else begin
            r_wrn_o <= 1'b0;
            if (w_tmo) begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_be_o    = r_be;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign wrn_o        = r_wrn_o;
  assign wrAddr_o     = r_wa_o;
  assign result_o     = r_res;
  assign align_err_o  = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_hs
// Purpose  : Self-checking bench for mem_stage_hs: directed vector table,
//            randomized ops against a behavioural model, and hand sequences
//            for reset-in-REQ and (with MEM_TIMEOUT_EN) the timeout paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_hs;

  localparam int ADDR_W = 32;
  localparam int REG_AW = 5;

  localparam logic [31:0] K_PASS  = 32'd0;
  localparam logic [31:0] K_LOAD  = 32'd1;
  localparam logic [31:0] K_STORE = 32'd2;
  localparam logic [31:0] K_MIS   = 32'd3;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] dly;
    logic        vld;
    logic        wrn;
    logic [4:0]  wa;
    logic [31:0] res_i;
    logic [31:0] kind;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] result;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [3:0]        mem_op_i;
  logic [31:0]       result_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wrdata_i;
  logic              wrn_i;
  logic [REG_AW-1:0] wrAddr_i;
  logic              stall_o;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [3:0]        dmem_be_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [31:0]       dmem_wdata_o;
  logic              dmem_ack_i;
  logic [31:0]       dmem_rdata_i;
  logic              wrn_o;
  logic [REG_AW-1:0] wrAddr_o;
  logic [31:0]       result_o;
  logic              align_err_o;
  logic              bus_err_o;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_hs #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .result_i(result_i), .mem_addr_i(mem_addr_i), .mem_wrdata_i(mem_wrdata_i),
    .wrn_i(wrn_i), .wrAddr_i(wrAddr_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wrn_o(wrn_o), .wrAddr_o(wrAddr_o), .result_o(result_o),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derives what the stage should do from the op rules alone
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input logic [31:0] dly, input logic vld,
                                 input logic wrn, input logic [4:0] wa,
                                 input logic [31:0] res_i);
    vec_t v;
    int size;
    bit is_ld, is_st;
    logic [31:0] sel, r;
    int lane;
    lane  = int'(addr % 4);
    is_ld = (op >= 4'd1 && op <= 4'd5);
    is_st = (op >= 4'd9 && op <= 4'd11);
    if (op == 4'd1 || op == 4'd2 || op == 4'd9) size = 1;
    else if (op == 4'd3 || op == 4'd4 || op == 4'd10) size = 2;
    else size = 4;
    v = '{op: op, addr: addr, wd: wd, rd: rd, dly: dly, vld: vld, wrn: wrn, wa: wa,
          res_i: res_i, kind: K_PASS, be: 4'd0, wdata: 32'd0, result: res_i};
    if (vld && (is_ld || is_st)) begin
      if ((addr % size) != 0) v.kind = K_MIS;
      else v.kind = is_ld ? K_LOAD : K_STORE;
    end
    v.be    = (size == 1) ? 4'(1 << lane) : (size == 2) ? 4'(3 << lane) : 4'd15;
    v.wdata = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    sel = rd >> (8 * lane);
    case (op)
      4'd1: begin r = sel & 32'hFF;   if (r >= 32'd128)   r = r - 32'd256;   end
      4'd2: r = sel & 32'hFF;
      4'd3: begin r = sel & 32'hFFFF; if (r >= 32'd32768) r = r - 32'd65536; end
      4'd4: r = sel & 32'hFFFF;
      default: r = rd;
    endcase
    if (v.kind == K_LOAD) v.result = r;
    return v;
  endfunction

  // Apply one instruction in an IDLE cycle and follow it to completion
  task automatic run_op(input vec_t v);
    valid_i      = v.vld;
    mem_op_i     = v.op;
    mem_addr_i   = v.addr;
    mem_wrdata_i = v.wd;
    result_i     = v.res_i;
    wrAddr_i     = v.wa;
    wrn_i        = v.wrn;
    dmem_ack_i   = (v.kind == K_PASS) ? 1'($urandom_range(0, 1)) : 1'b0;
    dmem_rdata_i = $urandom;
    #1;
    chk("stall_idle", {31'd0, stall_o}, {31'd0, (v.kind == K_LOAD || v.kind == K_STORE)});
    @(posedge clk); #1;
    if (v.kind == K_PASS) begin
      chk("pass_wrn", {31'd0, wrn_o}, {31'd0, v.vld & v.wrn});
      chk("pass_wa", {27'd0, wrAddr_o}, {27'd0, v.wa});
      chk("pass_res", result_o, v.res_i);
      chk("pass_req", {31'd0, dmem_req_o}, 32'd0);
    end else if (v.kind == K_MIS) begin
      chk("mis_wrn", {31'd0, wrn_o}, 32'd0);
      chk("mis_err", {31'd0, align_err_o}, 32'd1);
      chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk("mis_err_pulse", {31'd0, align_err_o}, 32'd0);
    end else begin
      chk("req", {31'd0, dmem_req_o}, 32'd1);
      chk("req_addr", dmem_addr_o, v.addr & ~32'd3);
      chk("req_be", {28'd0, dmem_be_o}, {28'd0, v.be});
      chk("req_we", {31'd0, dmem_we_o}, {31'd0, v.kind == K_STORE});
      if (v.kind == K_STORE) chk("req_wdata", dmem_wdata_o, v.wdata);
      chk("req_bubble", {31'd0, wrn_o}, 32'd0);
      for (int i = 0; i < int'(v.dly); i++) begin
        chk("stall_wait", {31'd0, stall_o}, 32'd1);
        dmem_rdata_i = $urandom;
        @(posedge clk); #1;
        chk("req_hold", {31'd0, dmem_req_o}, 32'd1);
      end
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = v.rd;
      #1;
      chk("stall_ack", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      valid_i    = 1'b0;
      chk("req_drop", {31'd0, dmem_req_o}, 32'd0);
      if (v.kind == K_LOAD) begin
        chk("ld_wrn", {31'd0, wrn_o}, {31'd0, v.wrn});
        chk("ld_wa", {27'd0, wrAddr_o}, {27'd0, v.wa});
        chk("ld_res", result_o, v.result);
      end else begin
        chk("st_wrn", {31'd0, wrn_o}, 32'd0);
      end
    end
  endtask

  vec_t tbl[14];

  initial begin
    logic [3:0] ops[11];
    vec_t v;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7, 4'd15};

    //            op     addr        wd            rd            dly  v  w  wa     res_i        kind     be       wdata         result
    tbl[0]  = '{4'd1,  32'h102, 32'h0,        32'h00800000, 32'd3, 1'b1, 1'b1, 5'd7, 32'h0, K_LOAD,  4'b0100, 32'h0,        32'hFFFFFF80};
    tbl[1]  = '{4'd2,  32'h102, 32'h0,        32'h00800000, 32'd3, 1'b1, 1'b1, 5'd8, 32'h0, K_LOAD,  4'b0100, 32'h0,        32'h00000080};
    tbl[2]  = '{4'd3,  32'h202, 32'h0,        32'h80010000, 32'd1, 1'b1, 1'b1, 5'd9, 32'h0, K_LOAD,  4'b1100, 32'h0,        32'hFFFF8001};
    tbl[3]  = '{4'd4,  32'h200, 32'h0,        32'h1234F00D, 32'd0, 1'b1, 1'b1, 5'd10, 32'h0, K_LOAD, 4'b0011, 32'h0,        32'h0000F00D};
    tbl[4]  = '{4'd5,  32'h010, 32'h0,        32'hDEADBEEF, 32'd2, 1'b1, 1'b1, 5'd31, 32'h0, K_LOAD, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[5]  = '{4'd10, 32'h006, 32'hABCD1234, 32'h0,        32'd0, 1'b1, 1'b1, 5'd1, 32'h0, K_STORE, 4'b1100, 32'h12341234, 32'h0};
    tbl[6]  = '{4'd9,  32'h003, 32'h77665544, 32'h0,        32'd1, 1'b1, 1'b1, 5'd2, 32'h0, K_STORE, 4'b1000, 32'h44444444, 32'h0};
    tbl[7]  = '{4'd11, 32'h008, 32'hCAFEBABE, 32'h0,        32'd0, 1'b1, 1'b0, 5'd2, 32'h0, K_STORE, 4'b1111, 32'hCAFEBABE, 32'h0};
    tbl[8]  = '{4'd5,  32'h005, 32'h0,        32'h0,        32'd0, 1'b1, 1'b1, 5'd4, 32'h0, K_MIS,   4'b0000, 32'h0,        32'h0};
    tbl[9]  = '{4'd10, 32'h001, 32'h0,        32'h0,        32'd0, 1'b1, 1'b1, 5'd4, 32'h0, K_MIS,   4'b0000, 32'h0,        32'h0};
    tbl[10] = '{4'd0,  32'h0,   32'h0,        32'h0,        32'd0, 1'b1, 1'b1, 5'd3, 32'h1234, K_PASS, 4'b0000, 32'h0,      32'h0};
    tbl[11] = '{4'd7,  32'h0,   32'h0,        32'h0,        32'd0, 1'b1, 1'b1, 5'd9, 32'h55AA, K_PASS, 4'b0000, 32'h0,      32'h0};
    tbl[12] = '{4'd5,  32'h0,   32'h0,        32'h0,        32'd0, 1'b0, 1'b1, 5'd6, 32'h77, K_PASS,  4'b0000, 32'h0,        32'h0};
    tbl[13] = '{4'd1,  32'h007, 32'h0,        32'h7F000000, 32'd0, 1'b1, 1'b1, 5'd5, 32'h0, K_LOAD,  4'b1000, 32'h0,        32'h0000007F};

    // Reset with a valid store applied: nothing may leave the stage
    rst = 1'b0; valid_i = 1'b1; mem_op_i = 4'd11; mem_addr_i = 32'h40;
    mem_wrdata_i = 32'hFFFF_FFFF; result_i = 32'hFFFF_FFFF; wrn_i = 1'b1;
    wrAddr_i = 5'd31; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_wrn", {31'd0, wrn_o}, 32'd0);
    chk("rst_wa", {27'd0, wrAddr_o}, 32'd0);
    chk("rst_res", result_o, 32'd0);
    chk("rst_align", {31'd0, align_err_o}, 32'd0);
    chk("rst_bus", {31'd0, bus_err_o}, 32'd0);
    valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_op(tbl[i]);

    // Reset while a request is outstanding aborts it without writeback
    v = model(4'd5, 32'h20, 32'h0, 32'h0, 32'd0, 1'b1, 1'b1, 5'd12, 32'h0);
    valid_i = 1'b1; mem_op_i = v.op; mem_addr_i = v.addr; wrn_i = 1'b1; wrAddr_i = 5'd12;
    @(posedge clk); #1;
    chk("rstreq_req", {31'd0, dmem_req_o}, 32'd1);
    rst = 1'b0; dmem_ack_i = 1'b1;
    @(posedge clk); #1;
    chk("rstreq_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("rstreq_wrn", {31'd0, wrn_o}, 32'd0);
    rst = 1'b1; dmem_ack_i = 1'b0; valid_i = 1'b0;
    run_op(model(4'd0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b1, 1'b1, 5'd13, 32'hA5A5_0001));

`ifdef MEM_TIMEOUT_EN
    // No ack at all: abort after the 15th REQ cycle
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h80; wrn_i = 1'b1; wrAddr_i = 5'd14;
    @(posedge clk); #1;
    for (int i = 1; i < 15; i++) begin
      chk("tmo_stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk); #1;
    end
    chk("tmo_stall_last", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("tmo_bus", {31'd0, bus_err_o}, 32'd1);
    chk("tmo_req", {31'd0, dmem_req_o}, 32'd0);
    chk("tmo_wrn", {31'd0, wrn_o}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_pulse", {31'd0, bus_err_o}, 32'd0);
    run_op(model(4'd0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b1, 1'b1, 5'd15, 32'h0BAD_F00D));
    // Ack arriving exactly on the limit cycle completes normally
    run_op(model(4'd5, 32'h84, 32'h0, 32'h1357_9BDF, 32'd14, 1'b1, 1'b1, 5'd16, 32'h0));
    chk("tmo_ack_bus", {31'd0, bus_err_o}, 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      v = model(ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom,
                32'($urandom_range(0, 4)), ($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      run_op(v);
      chk("rand_bus", {31'd0, bus_err_o}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
